// File: rtl/set_less_unit.sv
// rtl/set_less_unit.sv - signed/unsigned less-than comparator with optional output register
module set_less_unit #(
    parameter int N               = 32,
    parameter bit REGISTER_OUTPUT = 1'b0
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    input  logic [N-1:0] i_A,
    input  logic [N-1:0] i_B,
    output logic [N-1:0] o_IsLess,
    output logic [N-1:0] o_IsLessUnsigned
);

    logic [N-1:0] b_inv;
    logic [N-1:0] diff;
    logic [N:0]   carry;
    logic         overflow;
    logic         lt;
    logic         ltu;

    assign b_inv = ~i_B;

    // Ripple carry chain computing A + ~B + 1; carry[0] supplies the +1.
    always_comb begin
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            diff[i]    = i_A[i] ^ b_inv[i] ^ carry[i];
            carry[i+1] = (i_A[i] & b_inv[i]) | (carry[i] & (i_A[i] ^ b_inv[i]));
        end
    end

    // Overflow only possible when operand signs differ and the result sign flips from A.
    always_comb begin
        overflow = (i_A[N-1] != i_B[N-1]) && (diff[N-1] != i_A[N-1]);
        ltu      = ~carry[N];
        lt       = diff[N-1] ^ overflow;
    end

    generate
        if (REGISTER_OUTPUT) begin : g_reg
            logic lt_q;
            logic ltu_q;

            // One-cycle output stage; reset forces both results to false.
            always_ff @(posedge i_Clock) begin
                if (i_Reset) begin
                    lt_q  <= 1'b0;
                    ltu_q <= 1'b0;
                end else begin
                    lt_q  <= lt;
                    ltu_q <= ltu;
                end
            end

            assign o_IsLess         = {{(N-1){1'b0}}, lt_q};
            assign o_IsLessUnsigned = {{(N-1){1'b0}}, ltu_q};
        end else begin : g_comb
            // Clock and reset are intentionally ignored in the combinational build.
            logic unused_ctrl;
            assign unused_ctrl      = i_Clock ^ i_Reset;
            assign o_IsLess         = {{(N-1){1'b0}}, lt};
            assign o_IsLessUnsigned = {{(N-1){1'b0}}, ltu};
        end
    endgenerate

endmodule

// File: tb/tb_set_less_unit.sv
// tb/tb_set_less_unit.sv - directed and random checks of set_less_unit, both builds
module tb_set_less_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a   = '0;
    logic [31:0] b   = '0;
    logic [31:0] lt_c, ltu_c, lt_r, ltu_r;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    set_less_unit #(.N(32), .REGISTER_OUTPUT(1'b0)) dut_c (
        .i_Clock(clk), .i_Reset(rst), .i_A(a), .i_B(b),
        .o_IsLess(lt_c), .o_IsLessUnsigned(ltu_c)
    );

    set_less_unit #(.N(32), .REGISTER_OUTPUT(1'b1)) dut_r (
        .i_Clock(clk), .i_Reset(rst), .i_A(a), .i_B(b),
        .o_IsLess(lt_r), .o_IsLessUnsigned(ltu_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] va   [12];
    logic [31:0] vb   [12];
    logic [31:0] elt  [12];
    logic [31:0] eltu [12];

    initial begin
        va[0]  = 32'h00000000; vb[0]  = 32'h00000000; elt[0]  = 0; eltu[0]  = 0;
        va[1]  = 32'h00000000; vb[1]  = 32'h00000001; elt[1]  = 1; eltu[1]  = 1;
        va[2]  = 32'h00000001; vb[2]  = 32'h00000000; elt[2]  = 0; eltu[2]  = 0;
        va[3]  = 32'hFFFFFFFF; vb[3]  = 32'h00000001; elt[3]  = 1; eltu[3]  = 0;
        va[4]  = 32'h80000000; vb[4]  = 32'h00000000; elt[4]  = 1; eltu[4]  = 0;
        va[5]  = 32'h7FFFFFFF; vb[5]  = 32'h80000000; elt[5]  = 0; eltu[5]  = 1;
        va[6]  = 32'h80000000; vb[6]  = 32'h7FFFFFFF; elt[6]  = 1; eltu[6]  = 0;
        va[7]  = 32'hFFFFFFFF; vb[7]  = 32'hFFFFFFFE; elt[7]  = 0; eltu[7]  = 0;
        va[8]  = 32'hFFFFFFFE; vb[8]  = 32'hFFFFFFFF; elt[8]  = 1; eltu[8]  = 1;
        va[9]  = 32'h00000000; vb[9]  = 32'hFFFFFFFF; elt[9]  = 0; eltu[9]  = 1;
        va[10] = 32'hFFFFFFFF; vb[10] = 32'h00000000; elt[10] = 1; eltu[10] = 0;
        va[11] = 32'h12345678; vb[11] = 32'h12345679; elt[11] = 1; eltu[11] = 1;

        // Combinational build: directed vectors.
        for (int k = 0; k < 12; k++) begin
            a = va[k]; b = vb[k];
            #1;
            chk($sformatf("comb_lt_%0d", k), lt_c, elt[k]);
            chk($sformatf("comb_ltu_%0d", k), ltu_c, eltu[k]);
        end

        // Combinational build: random regression against the language operators.
        for (int k = 0; k < 20000; k++) begin
            logic [31:0] ra, rb, xl, xu;
            ra = $urandom;
            case (k % 8)
                0:       rb = ra;
                1:       rb = ra + 32'd1;
                2:       rb = ra ^ 32'h80000000;
                default: rb = $urandom;
            endcase
            a = ra; b = rb;
            #1;
            xl = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
            xu = (ra < rb) ? 32'd1 : 32'd0;
            chk("rand_lt", lt_c, xl);
            chk("rand_ltu", ltu_c, xu);
        end

        // Registered build: reset clears outputs and holds them while asserted.
        @(negedge clk);
        rst = 1'b1; a = 32'h00000000; b = 32'h00000001;
        @(posedge clk); #1;
        chk("reg_rst_lt", lt_r, 32'd0);
        chk("reg_rst_ltu", ltu_r, 32'd0);
        @(posedge clk); #1;
        chk("reg_rst_hold_lt", lt_r, 32'd0);
        chk("reg_rst_hold_ltu", ltu_r, 32'd0);

        // First post-reset edge samples the current inputs.
        @(negedge clk);
        rst = 1'b0; a = 32'hFFFFFFFF; b = 32'h00000001;
        @(posedge clk); #1;
        chk("reg_first_lt", lt_r, 32'd1);
        chk("reg_first_ltu", ltu_r, 32'd0);

        // Back-to-back operands: outputs hold until the edge, then show exactly one-cycle-old result.
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            a = va[k]; b = vb[k];
            #1;
            chk($sformatf("reg_hold_lt_%0d", k), lt_r, (k == 1) ? 32'd1 : elt[k-1]);
            chk($sformatf("reg_hold_ltu_%0d", k), ltu_r, (k == 1) ? 32'd0 : eltu[k-1]);
            @(posedge clk); #1;
            chk($sformatf("reg_lt_%0d", k), lt_r, elt[k]);
            chk($sformatf("reg_ltu_%0d", k), ltu_r, eltu[k]);
        end

        // Reset asserted mid-stream clears a true result.
        @(negedge clk);
        rst = 1'b1; a = 32'h00000000; b = 32'h00000001;
        @(posedge clk); #1;
        chk("reg_rst2_lt", lt_r, 32'd0);
        chk("reg_rst2_ltu", ltu_r, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
